drum_seq_ctrl: RTL and testbench

Sequencing controller for the four-instrument, eight-step drum datapath. Walks the user through BPM entry and the four instrument patterns using a single advance button. Issues one-cycle load strobes to the datapath, then runs playback by generating the BPM-derived step tick and the 1..8 step index the datapath uses to select pattern bits.

---
 rtl/drum_ctrl_pkg.sv | 15 +
 rtl/step_tick_gen.sv | 46 ++++
 rtl/drum_seq_ctrl.sv | 89 ++++++++
 tb/tb_drum_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/drum_ctrl_pkg.sv
// drum_ctrl_pkg: shared state codes and step constants for the drum sequencer
package drum_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_BPM = 3'd1,
    S_LOAD_I1  = 3'd2,
    S_LOAD_I2  = 3'd3,
    S_LOAD_I3  = 3'd4,
    S_LOAD_I4  = 3'd5,
    S_PLAY     = 3'd6,
    S_PAUSE    = 3'd7
  } drum_state_e;
  localparam int STEPS        = 8;
  localparam int TIMING_FIRST = 1;
endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: BPM phase accumulator producing step_tick and the 1..8 step index
// Ports: clk, reset (sync, active-low), run (advance this edge), clear (zero phase;
//        timing loads 1 when run else 0), bpm, step_tick (1-cycle pulse), timing.
module step_tick_gen
  import drum_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 1_500_000_000,
  parameter int ACC_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  input  logic [7:0] bpm,
  output logic       step_tick,
  output logic [3:0] timing
);
  localparam logic [ACC_W:0] DIV = (ACC_W+1)'(STEP_DIV);
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;
  logic             hit;
  logic             tick_q;
  logic [3:0]       timing_q;
  // one spare carry bit so a large threshold plus bpm can never wrap
  assign sum       = {1'b0, acc_q} + (ACC_W+1)'(bpm);
  assign hit       = sum >= DIV;
  assign step_tick = tick_q;
  assign timing    = timing_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q    <= '0;
      tick_q   <= 1'b0;
      timing_q <= '0;
    end else if (clear) begin
      acc_q    <= '0;
      tick_q   <= 1'b0;
      timing_q <= run ? 4'(TIMING_FIRST) : 4'd0;
    end else if (run) begin
      acc_q    <= hit ? ACC_W'(sum - DIV) : sum[ACC_W-1:0];
      tick_q   <= hit;
      timing_q <= !hit ? timing_q : (timing_q == 4'(STEPS)) ? 4'(TIMING_FIRST) : timing_q + 4'd1;
    end else begin
      tick_q   <= 1'b0;
    end
  end
endmodule

// File: rtl/drum_seq_ctrl.sv
// drum_seq_ctrl: single-button entry of BPM and four patterns, then step playback
// Ports: clk, reset (sync, active-low), go (advance, level), stop (abort to IDLE),
//        sel (BPM switches); outputs ld_bpm/ld_ins1..4 strobes, play, timing 1..8,
//        step_tick, bpm, state code.
// Build option: define PAUSE_DRUM_EN to let go toggle PLAY <-> PAUSE.
module drum_seq_ctrl
  import drum_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 1_500_000_000,
  parameter int ACC_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       stop,
  input  logic [7:0] sel,
  output logic       ld_bpm,
  output logic       ld_ins1,
  output logic       ld_ins2,
  output logic       ld_ins3,
  output logic       ld_ins4,
  output logic       play,
  output logic [3:0] timing,
  output logic       step_tick,
  output logic [7:0] bpm,
  output logic [2:0] state
);
  drum_state_e state_q;
  logic        go_q;
  logic        play_q;
  logic [4:0]  ld_q;
  logic [7:0]  bpm_q;
  logic        go_rise;
  logic        enter;
  logic        run;
  logic        clear;
  assign go_rise = go & ~go_q;
  assign enter   = (state_q == S_LOAD_I4) & go_rise & ~stop;
  // run is high on every edge whose next state is PLAY, so the pausing edge holds phase
`ifdef PAUSE_DRUM_EN
  assign run = enter | (~stop & (((state_q == S_PLAY) & ~go_rise) | ((state_q == S_PAUSE) & go_rise)));
`else
  assign run = enter | ((state_q == S_PLAY) & ~stop);
`endif
  assign clear = enter | (stop & ((state_q == S_PLAY) | (state_q == S_PAUSE)));
  assign {ld_ins4, ld_ins3, ld_ins2, ld_ins1, ld_bpm} = ld_q;
  assign play  = play_q;
  assign bpm   = bpm_q;
  assign state = state_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      play_q  <= 1'b0;
      ld_q    <= '0;
      bpm_q   <= '0;
    end else begin
      go_q <= go;
      ld_q <= '0;
      if (stop) begin
        state_q <= S_IDLE;
        play_q  <= 1'b0;
      end else if (go_rise) begin
        case (state_q)
          S_IDLE:     state_q <= S_LOAD_BPM;
          S_LOAD_BPM: begin state_q <= S_LOAD_I1; bpm_q <= sel; ld_q <= 5'b00001; end
          S_LOAD_I1:  begin state_q <= S_LOAD_I2; ld_q <= 5'b00010; end
          S_LOAD_I2:  begin state_q <= S_LOAD_I3; ld_q <= 5'b00100; end
          S_LOAD_I3:  begin state_q <= S_LOAD_I4; ld_q <= 5'b01000; end
          S_LOAD_I4:  begin state_q <= S_PLAY; ld_q <= 5'b10000; play_q <= 1'b1; end
`ifdef PAUSE_DRUM_EN
          S_PLAY:     begin state_q <= S_PAUSE; play_q <= 1'b0; end
          S_PAUSE:    begin state_q <= S_PLAY; play_q <= 1'b1; end
`endif
          default:    state_q <= state_q;
        endcase
      end
    end
  end
  step_tick_gen #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .clear     (clear),
    .bpm       (bpm_q),
    .step_tick (step_tick),
    .timing    (timing)
  );
endmodule

// File: tb/tb_drum_seq_ctrl.sv
// tb_drum_seq_ctrl: directed table plus multi-cycle sequences for drum_seq_ctrl
module tb_drum_seq_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] sel = '0;
  logic       ld_bpm, ld_ins1, ld_ins2, ld_ins3, ld_ins4, play, step_tick;
  logic [3:0] timing;
  logic [7:0] bpm;
  logic [2:0] state;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  drum_seq_ctrl #(.STEP_DIV(16), .ACC_W(8)) dut (
    .clk(clk), .reset(reset), .go(go), .stop(stop), .sel(sel),
    .ld_bpm(ld_bpm), .ld_ins1(ld_ins1), .ld_ins2(ld_ins2), .ld_ins3(ld_ins3), .ld_ins4(ld_ins4),
    .play(play), .timing(timing), .step_tick(step_tick), .bpm(bpm), .state(state)
  );
  typedef struct {
    logic       go;
    logic [7:0] sel;
    logic [2:0] st;
    logic [4:0] ld;
    logic       play;
    logic [3:0] tim;
    logic [7:0] bpm;
  } vec_t;
  vec_t v[13];
  function automatic logic [4:0] lds();
    return {ld_ins4, ld_ins3, ld_ins2, ld_ins1, ld_bpm};
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic go_pulse(input logic [7:0] s);
    go = 1'b1;
    sel = s;
    cyc();
    go = 1'b0;
    cyc();
  endtask
  // from IDLE to PLAY; returns one edge after PLAY entry
  task automatic load_seq(input logic [7:0] b);
    go_pulse(8'h00);
    go_pulse(b);
    go_pulse(8'hA5);
    go_pulse(8'h0F);
    go_pulse(8'hF0);
    go_pulse(8'h81);
    chk("load_state", state, 6);
    chk("load_timing", timing, 1);
    chk("load_bpm", bpm, b);
  endtask
  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_state", state, 0);
    chk("stop_play", play, 0);
    chk("stop_timing", timing, 0);
    chk("stop_tick", step_tick, 0);
  endtask
  initial begin
    int t3[9] = '{6, 11, 16, 22, 27, 32, 38, 43, 48};
    int k;
    int exp_t;
    logic e;
    v[0]  = '{1'b1, 8'h04, 3'd1, 5'b00000, 1'b0, 4'd0, 8'd0};
    v[1]  = '{1'b1, 8'h04, 3'd1, 5'b00000, 1'b0, 4'd0, 8'd0};
    v[2]  = '{1'b0, 8'h04, 3'd1, 5'b00000, 1'b0, 4'd0, 8'd0};
    v[3]  = '{1'b1, 8'h04, 3'd2, 5'b00001, 1'b0, 4'd0, 8'd4};
    v[4]  = '{1'b0, 8'hA5, 3'd2, 5'b00000, 1'b0, 4'd0, 8'd4};
    v[5]  = '{1'b1, 8'hA5, 3'd3, 5'b00010, 1'b0, 4'd0, 8'd4};
    v[6]  = '{1'b0, 8'h0F, 3'd3, 5'b00000, 1'b0, 4'd0, 8'd4};
    v[7]  = '{1'b1, 8'h0F, 3'd4, 5'b00100, 1'b0, 4'd0, 8'd4};
    v[8]  = '{1'b0, 8'hF0, 3'd4, 5'b00000, 1'b0, 4'd0, 8'd4};
    v[9]  = '{1'b1, 8'hF0, 3'd5, 5'b01000, 1'b0, 4'd0, 8'd4};
    v[10] = '{1'b0, 8'h81, 3'd5, 5'b00000, 1'b0, 4'd0, 8'd4};
    v[11] = '{1'b1, 8'h81, 3'd6, 5'b10000, 1'b1, 4'd1, 8'd4};
    v[12] = '{1'b0, 8'h81, 3'd6, 5'b00000, 1'b1, 4'd1, 8'd4};
    go = 1'b1;
    repeat (3) cyc();
    chk("rst_state", state, 0);
    chk("rst_ld", lds(), 0);
    chk("rst_play", play, 0);
    chk("rst_timing", timing, 0);
    chk("rst_tick", step_tick, 0);
    chk("rst_bpm", bpm, 0);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      go = v[i].go;
      sel = v[i].sel;
      cyc();
      chk($sformatf("vec%0d_state", i), state, v[i].st);
      chk($sformatf("vec%0d_ld", i), lds(), v[i].ld);
      chk($sformatf("vec%0d_play", i), play, v[i].play);
      chk($sformatf("vec%0d_timing", i), timing, v[i].tim);
      chk($sformatf("vec%0d_bpm", i), bpm, v[i].bpm);
      chk($sformatf("vec%0d_tick", i), step_tick, 0);
    end
    for (int c = 2; c <= 33; c++) begin
      cyc();
      chk($sformatf("bpm4_tick_c%0d", c), step_tick, (c % 4 == 0) ? 1 : 0);
      chk($sformatf("bpm4_timing_c%0d", c), timing, ((c / 4) % 8) + 1);
    end
    do_stop();
    load_seq(8'd3);
    k = 0;
    exp_t = 1;
    for (int c = 2; c <= 48; c++) begin
      cyc();
      e = (k < 9) && (t3[k] == c);
      if (e) begin
        k++;
        exp_t = (exp_t == 8) ? 1 : exp_t + 1;
      end
      chk($sformatf("bpm3_tick_c%0d", c), step_tick, e);
      chk($sformatf("bpm3_timing_c%0d", c), timing, exp_t);
    end
    do_stop();
    go_pulse(8'h00);
    go_pulse(8'h07);
    go_pulse(8'hA5);
    chk("i2_state", state, 3);
    go = 1'b1;
    stop = 1'b1;
    cyc();
    chk("stopgo_state", state, 0);
    chk("stopgo_ld", lds(), 0);
    go = 1'b0;
    stop = 1'b0;
    cyc();
    chk("stopgo_state2", state, 0);
    chk("stopgo_ld2", lds(), 0);
    load_seq(8'd0);
    for (int c = 0; c < 100; c++) begin
      cyc();
      chk("bpm0_tick", step_tick, 0);
      chk("bpm0_timing", timing, 1);
    end
    do_stop();
    load_seq(8'd4);
`ifdef PAUSE_DRUM_EN
    repeat (16) cyc();
    chk("pre_pause_timing", timing, 5);
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("pause_state", state, 7);
    chk("pause_play", play, 0);
    chk("pause_timing", timing, 5);
    for (int c = 0; c < 50; c++) begin
      cyc();
      chk("pause_hold_timing", timing, 5);
      chk("pause_hold_tick", step_tick, 0);
      chk("pause_hold_state", state, 7);
    end
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("resume_state", state, 6);
    chk("resume_play", play, 1);
    chk("resume_tick0", step_tick, 0);
    cyc();
    chk("resume_tick1", step_tick, 0);
    cyc();
    chk("resume_tick2", step_tick, 1);
    chk("resume_timing", timing, 6);
    go_pulse(8'h00);
    chk("pause2_state", state, 7);
    do_stop();
    load_seq(8'd4);
`else
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("nopause_state", state, 6);
    chk("nopause_play", play, 1);
    chk("nopause_tick2", step_tick, 0);
    cyc();
    chk("nopause_tick3", step_tick, 0);
    cyc();
    chk("nopause_tick4", step_tick, 1);
    chk("nopause_timing4", timing, 2);
    chk("nopause_state4", state, 6);
`endif
    go = 1'b1;
    reset = 1'b0;
    cyc();
    chk("midrst_state", state, 0);
    chk("midrst_play", play, 0);
    chk("midrst_timing", timing, 0);
    chk("midrst_tick", step_tick, 0);
    chk("midrst_bpm", bpm, 0);
    chk("midrst_ld", lds(), 0);
    reset = 1'b1;
    go = 1'b0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
